mem_stage: RTL and testbench
============================

MEM_STAGE -- requirements
Module: mem_stage

Interface
REQ-001 SHALL have: clk  input  1  single clock, all state updates on rising edge.
REQ-002 SHALL have: rst  input  1  synchronous, active-low reset (rst=0 resets on next rising edge).
REQ-003 SHALL have: valid_in  input  1  operation present from ex_m.
REQ-004 SHALL have: mem_op_in  input  2  NONE=0, LOAD=1, STORE=2 (3 treated as NONE).
REQ-005 SHALL have: funct3_in  input  3  RISC-V access width/sign code.
REQ-006 SHALL have: rd_addr_in  input  5  destination register.
REQ-007 SHALL have: rd_in  input  32  ALU result / effective address.
REQ-008 SHALL have: store_data_in  input  32  rs2 value for stores.
REQ-009 SHALL have: writeback_en_in  input  1  writeback request.
REQ-010 SHALL have: stall_out  output  1  upstream holds all inputs stable while high.
REQ-011 SHALL have: rd_addr_out  output  5  to writeback stage.
REQ-012 SHALL have: rd_out  output  32  result to writeback stage.
REQ-013 SHALL have: writeback_en_out  output  1  result valid for register write.
REQ-014 SHALL have: misalign_out  output  1  misaligned-access pulse.
REQ-015 SHALL have: mem_req  output  1  data-memory request, held until mem_ack.
REQ-016 SHALL have: mem_we  output  1  store when high.
REQ-017 SHALL have: mem_addr  output  32  word-aligned address, {rd_in[31:2],2'b00}.
REQ-018 SHALL have: mem_wdata  output  32  lane-replicated store data.
REQ-019 SHALL have: mem_be  output  4  byte enables.
REQ-020 SHALL have: mem_ack  input  1  completes request, any number of cycles after mem_req (including the first).
REQ-021 SHALL have: mem_rdata  input  32  load data, valid with mem_ack.

Function
REQ-022 SHALL implement FSM IDLE, BUSY, DONE; all outputs except stall_out registered.
REQ-023 IDLE, non-memory op: SHALL register rd_addr_in, rd_in, writeback_en_in&valid_in to outputs, 1-cycle latency, stall_out=0.
REQ-024 IDLE, valid LOAD/STORE: SHALL drive stall_out=1 combinationally, register mem_req=1 plus addr/we/wdata/be, output bubble (writeback_en_out=0), go BUSY.
REQ-025 BUSY: SHALL hold stall_out=1 and mem_req/addr/we/wdata/be stable until mem_ack.
REQ-026 BUSY with mem_ack: SHALL deassert mem_req, register result (load: aligned data, writeback_en_out=writeback_en_in; store: writeback_en_out=0), go DONE.
REQ-027 DONE: SHALL present result one cycle, stall_out=0, issue no request, next outputs bubble, go IDLE; minimum load/store occupancy 3 cycles.
REQ-028 Loads SHALL select lane by rd_in[1:0]: LB/LBU byte, LH/LHU halfword, sign- or zero-extended; LW and undefined funct3 as word.
REQ-029 Stores SHALL set mem_be SB=0001<<a[1:0], SH=0011<<{a[1],0}, SW/undefined=1111, mem_wdata byte/half replicated across lanes.
REQ-030 mem_ack outside BUSY SHALL be ignored.

Reset
REQ-031 rst=0 SHALL force state IDLE, mem_req=0, mem_we=0, mem_be=0, mem_addr=0, mem_wdata=0, rd_addr_out=0, rd_out=0, writeback_en_out=0, misalign_out=0, including mid-BUSY (outstanding ack then ignored).

Configuration
REQ-032 With MEM_STAGE_MISALIGN_TRAP_EN defined, a misaligned LH/LHU/SH (a[0]=1) or LW/SW (a[1:0]!=0) SHALL issue no request, pulse misalign_out one cycle, writeback_en_out=0, stall_out=0; without it misalign_out SHALL be tied 0 and offending low address bits ignored (half uses a[1], word lane 0).

Structure
REQ-033 Shared package SHALL hold mem_op_t enum, funct3 load/store constants, and FSM state type; load extraction/extension SHALL be sub-module mem_load_align.

Verification
REQ-034 ADD result 0x1234, rd=5, wb=1, IDLE -> next cycle rd_out=0x1234, rd_addr_out=5, writeback_en_out=1, stall_out never high.
REQ-035 LB addr 0x103, mem_rdata 0x80FFFFFF, ack 2 cycles after req -> mem_addr 0x100, rd_out 0xFFFFFF80, one valid writeback cycle.
REQ-036 SH addr 0x102, data 0xABCD, zero-wait ack -> mem_be=1100, mem_wdata 0xABCDABCD, mem_we=1, writeback_en_out stays 0.
REQ-037 LW in BUSY, rst=0 for one cycle before ack -> mem_req=0 next edge, all outputs 0, later ack ignored.
REQ-038 LW addr 0x101 with MEM_STAGE_MISALIGN_TRAP_EN -> mem_req stays 0, misalign_out=1 for one cycle; without macro -> request to 0x100, word returned.

Source files
------------

// File: rtl/mem_stage_pkg.sv
// Shared types, funct3 codes and access helpers for the memory stage.
package mem_stage_pkg;

  localparam int unsigned XLEN   = 32;
  localparam int unsigned REG_AW = 5;
  localparam int unsigned BE_W   = 4;

  typedef enum logic [1:0] {
    MEM_NONE  = 2'd0,
    MEM_LOAD  = 2'd1,
    MEM_STORE = 2'd2
  } mem_op_t;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;
  localparam logic [2:0] F3_SB  = 3'b000;
  localparam logic [2:0] F3_SH  = 3'b001;
  localparam logic [2:0] F3_SW  = 3'b010;

  // Undefined funct3 codes fall through to word-sized accesses.
  function automatic logic is_byte(input logic is_store, input logic [2:0] f3);
    return is_store ? (f3 == F3_SB) : (f3 == F3_LB || f3 == F3_LBU);
  endfunction

  function automatic logic is_half(input logic is_store, input logic [2:0] f3);
    return is_store ? (f3 == F3_SH) : (f3 == F3_LH || f3 == F3_LHU);
  endfunction

  function automatic logic [BE_W-1:0] access_be(input logic is_store, input logic [2:0] f3,
                                                input logic [1:0] a);
    if (is_byte(is_store, f3))      return 4'b0001 << a;
    else if (is_half(is_store, f3)) return a[1] ? 4'b1100 : 4'b0011;
    else                            return 4'b1111;
  endfunction

  function automatic logic [XLEN-1:0] store_wdata(input logic [2:0] f3,
                                                  input logic [XLEN-1:0] d);
    if (f3 == F3_SB)      return {4{d[7:0]}};
    else if (f3 == F3_SH) return {2{d[15:0]}};
    else                  return d;
  endfunction

  function automatic logic misaligned(input logic is_store, input logic [2:0] f3,
                                      input logic [1:0] a);
    return (is_half(is_store, f3) && a[0]) || (f3 == F3_LW && a != 2'b00);
  endfunction

endpackage

// File: rtl/mem_stage_if.sv
// Data-memory request/response bus between the memory stage and memory.
interface mem_stage_if;
  import mem_stage_pkg::*;

  logic            mem_req;
  logic            mem_we;
  logic [XLEN-1:0] mem_addr;
  logic [XLEN-1:0] mem_wdata;
  logic [BE_W-1:0] mem_be;
  logic            mem_ack;
  logic [XLEN-1:0] mem_rdata;

  modport master (output mem_req, mem_we, mem_addr, mem_wdata, mem_be,
                  input  mem_ack, mem_rdata);
  modport slave  (input  mem_req, mem_we, mem_addr, mem_wdata, mem_be,
                  output mem_ack, mem_rdata);
endinterface

// File: rtl/mem_load_align.sv
// Extracts the addressed byte/halfword from a load word and sign/zero-extends it.
module mem_load_align
  import mem_stage_pkg::*;
(
  input  logic [2:0]      funct3,
  input  logic [1:0]      addr_lo,
  input  logic [XLEN-1:0] rdata,
  output logic [XLEN-1:0] data_c
);

  logic [7:0]  byte_c;
  logic [15:0] half_c;

  always_comb begin
    byte_c = rdata[7:0];
    case (addr_lo)
      2'd1:    byte_c = rdata[15:8];
      2'd2:    byte_c = rdata[23:16];
      2'd3:    byte_c = rdata[31:24];
      default: byte_c = rdata[7:0];
    endcase
    half_c = addr_lo[1] ? rdata[31:16] : rdata[15:0];
  end

  always_comb begin
    data_c = rdata;
    case (funct3)
      F3_LB:   data_c = {{24{byte_c[7]}}, byte_c};
      F3_LBU:  data_c = {24'd0, byte_c};
      F3_LH:   data_c = {{16{half_c[15]}}, half_c};
      F3_LHU:  data_c = {16'd0, half_c};
      default: data_c = rdata;
    endcase
  end

endmodule

// File: rtl/mem_stage.sv
// Pipeline memory stage: passes ALU results through, runs loads/stores on a req/ack bus.
// Optional MEM_STAGE_MISALIGN_TRAP_EN turns misaligned half/word accesses into a misalign pulse.
module mem_stage
  import mem_stage_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              valid_in,
  input  logic [1:0]        mem_op_in,
  input  logic [2:0]        funct3_in,
  input  logic [REG_AW-1:0] rd_addr_in,
  input  logic [XLEN-1:0]   rd_in,
  input  logic [XLEN-1:0]   store_data_in,
  input  logic              writeback_en_in,
  output logic              stall_out,
  output logic [REG_AW-1:0] rd_addr_out,
  output logic [XLEN-1:0]   rd_out,
  output logic              writeback_en_out,
  output logic              misalign_out,
  mem_stage_if.master       mem
);

  state_t            state, state_nxt;
  logic              req_nxt, we_nxt, wb_nxt, misalign_nxt;
  logic [XLEN-1:0]   addr_nxt, wdata_nxt, rd_nxt;
  logic [BE_W-1:0]   be_nxt;
  logic [REG_AW-1:0] rd_addr_nxt;
  logic              is_load_c, is_store_c, is_mem_c, mis_c;
  logic [XLEN-1:0]   load_data_c;

  assign is_load_c  = valid_in && (mem_op_in == MEM_LOAD);
  assign is_store_c = valid_in && (mem_op_in == MEM_STORE);
  assign is_mem_c   = is_load_c || is_store_c;

`ifdef MEM_STAGE_MISALIGN_TRAP_EN
  assign mis_c = is_mem_c && misaligned(is_store_c, funct3_in, rd_in[1:0]);
`else
  assign mis_c = 1'b0;
`endif

  mem_load_align u_align (
    .funct3  (funct3_in),
    .addr_lo (rd_in[1:0]),
    .rdata   (mem.mem_rdata),
    .data_c  (load_data_c)
  );

  // Next-state and next-output logic; registers hold unless a branch updates them.
  always_comb begin
    state_nxt    = state;
    stall_out    = 1'b0;
    req_nxt      = mem.mem_req;
    we_nxt       = mem.mem_we;
    addr_nxt     = mem.mem_addr;
    wdata_nxt    = mem.mem_wdata;
    be_nxt       = mem.mem_be;
    rd_addr_nxt  = rd_addr_out;
    rd_nxt       = rd_out;
    wb_nxt       = 1'b0;
    misalign_nxt = 1'b0;
    case (state)
      ST_IDLE: begin
        if (mis_c) begin
          misalign_nxt = 1'b1;
        end else if (is_mem_c) begin
          stall_out = 1'b1;
          req_nxt   = 1'b1;
          we_nxt    = is_store_c;
          addr_nxt  = {rd_in[XLEN-1:2], 2'b00};
          wdata_nxt = store_wdata(funct3_in, store_data_in);
          be_nxt    = access_be(is_store_c, funct3_in, rd_in[1:0]);
          state_nxt = ST_BUSY;
        end else begin
          rd_addr_nxt = rd_addr_in;
          rd_nxt      = rd_in;
          wb_nxt      = writeback_en_in && valid_in;
        end
      end
      ST_BUSY: begin
        stall_out = 1'b1;
        if (mem.mem_ack) begin
          req_nxt   = 1'b0;
          state_nxt = ST_DONE;
          if (!mem.mem_we) begin
            rd_addr_nxt = rd_addr_in;
            rd_nxt      = load_data_c;
            wb_nxt      = writeback_en_in;
          end
        end
      end
      ST_DONE: state_nxt = ST_IDLE;
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state            <= ST_IDLE;
      mem.mem_req      <= 1'b0;
      mem.mem_we       <= 1'b0;
      mem.mem_addr     <= '0;
      mem.mem_wdata    <= '0;
      mem.mem_be       <= '0;
      rd_addr_out      <= '0;
      rd_out           <= '0;
      writeback_en_out <= 1'b0;
      misalign_out     <= 1'b0;
    end else begin
      state            <= state_nxt;
      mem.mem_req      <= req_nxt;
      mem.mem_we       <= we_nxt;
      mem.mem_addr     <= addr_nxt;
      mem.mem_wdata    <= wdata_nxt;
      mem.mem_be       <= be_nxt;
      rd_addr_out      <= rd_addr_nxt;
      rd_out           <= rd_nxt;
      writeback_en_out <= wb_nxt;
      misalign_out     <= misalign_nxt;
    end
  end

endmodule

// File: tb/tb_mem_stage.sv
// Directed self-checking bench for mem_stage; follows MEM_STAGE_MISALIGN_TRAP_EN if defined.
module tb_mem_stage;
  import mem_stage_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        valid_in;
  logic [1:0]  mem_op_in;
  logic [2:0]  funct3_in;
  logic [4:0]  rd_addr_in;
  logic [31:0] rd_in;
  logic [31:0] store_data_in;
  logic        writeback_en_in;
  logic        stall_out;
  logic [4:0]  rd_addr_out;
  logic [31:0] rd_out;
  logic        writeback_en_out;
  logic        misalign_out;

  int n_vec = 0;
  int n_err = 0;

  mem_stage_if bus ();

  mem_stage dut (
    .clk              (clk),
    .rst              (rst),
    .valid_in         (valid_in),
    .mem_op_in        (mem_op_in),
    .funct3_in        (funct3_in),
    .rd_addr_in       (rd_addr_in),
    .rd_in            (rd_in),
    .store_data_in    (store_data_in),
    .writeback_en_in  (writeback_en_in),
    .stall_out        (stall_out),
    .rd_addr_out      (rd_addr_out),
    .rd_out           (rd_out),
    .writeback_en_out (writeback_en_out),
    .misalign_out     (misalign_out),
    .mem              (bus.master)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [1:0] op, input logic [2:0] f3,
                       input logic [4:0] ra, input logic [31:0] a, input logic [31:0] sd,
                       input logic wb);
    valid_in = v; mem_op_in = op; funct3_in = f3; rd_addr_in = ra;
    rd_in = a; store_data_in = sd; writeback_en_in = wb;
  endtask

  // One load/store: lat = number of BUSY cycles without ack before the ack cycle.
  task automatic mem_txn(input string tag, input logic [1:0] op, input logic [2:0] f3,
                         input logic [31:0] a, input logic [31:0] sd, input logic [31:0] rdata,
                         input int lat, input logic [3:0] exp_be, input logic [31:0] exp_wdata,
                         input logic [31:0] exp_rd, input logic exp_wb);
    drive(1'b1, op, f3, 5'd9, a, sd, 1'b1);
    #1 check({tag, "_stall_idle"}, 32'(stall_out), 32'd1);
    tick();
    check({tag, "_req"},  32'(bus.mem_req), 32'd1);
    check({tag, "_addr"}, bus.mem_addr, {a[31:2], 2'b00});
    check({tag, "_we"},   32'(bus.mem_we), 32'(op == MEM_STORE));
    check({tag, "_be"},   32'(bus.mem_be), 32'(exp_be));
    if (op == MEM_STORE) check({tag, "_wdata"}, bus.mem_wdata, exp_wdata);
    check({tag, "_bubble"}, 32'(writeback_en_out), 32'd0);
    for (int i = 0; i < lat; i++) begin
      tick();
      check({tag, "_hold_req"}, 32'(bus.mem_req), 32'd1);
      check({tag, "_hold_stall"}, 32'(stall_out), 32'd1);
    end
    bus.mem_ack = 1'b1; bus.mem_rdata = rdata;
    tick();
    bus.mem_ack = 1'b0; bus.mem_rdata = 32'hxxxx_xxxx;
    check({tag, "_req_drop"}, 32'(bus.mem_req), 32'd0);
    check({tag, "_wb"}, 32'(writeback_en_out), 32'(exp_wb));
    check({tag, "_stall_done"}, 32'(stall_out), 32'd0);
    if (exp_wb) begin
      check({tag, "_rd"}, rd_out, exp_rd);
      check({tag, "_rd_addr"}, 32'(rd_addr_out), 32'd9);
    end
    drive(1'b0, MEM_NONE, 3'd0, 5'd0, 32'd0, 32'd0, 1'b0);
    tick();
    check({tag, "_wb_single"}, 32'(writeback_en_out), 32'd0);
    check({tag, "_no_req"}, 32'(bus.mem_req), 32'd0);
  endtask

  initial begin
    rst = 1'b0;
    bus.mem_ack = 1'b0; bus.mem_rdata = 32'd0;
    drive(1'b0, MEM_NONE, 3'd0, 5'd0, 32'd0, 32'd0, 1'b0);
    tick(); tick();
    rst = 1'b1;
    check("rst_req",   32'(bus.mem_req), 32'd0);
    check("rst_be",    32'(bus.mem_be), 32'd0);
    check("rst_rd",    rd_out, 32'd0);
    check("rst_wb",    32'(writeback_en_out), 32'd0);
    check("rst_mis",   32'(misalign_out), 32'd0);
    check("rst_stall", 32'(stall_out), 32'd0);

    // ALU passthrough
    drive(1'b1, MEM_NONE, 3'd0, 5'd5, 32'h0000_1234, 32'd0, 1'b1);
    #1 check("add_stall", 32'(stall_out), 32'd0);
    tick();
    check("add_rd", rd_out, 32'h0000_1234);
    check("add_rd_addr", 32'(rd_addr_out), 32'd5);
    check("add_wb", 32'(writeback_en_out), 32'd1);
    check("add_stall2", 32'(stall_out), 32'd0);
    drive(1'b1, 2'd3, 3'd0, 5'd6, 32'h0000_0077, 32'd0, 1'b1);
    tick();
    check("op3_rd", rd_out, 32'h0000_0077);
    check("op3_req", 32'(bus.mem_req), 32'd0);
    drive(1'b0, MEM_NONE, 3'd0, 5'd6, 32'h0000_0055, 32'd0, 1'b1);
    tick();
    check("invalid_wb", 32'(writeback_en_out), 32'd0);

    mem_txn("lb",  MEM_LOAD,  F3_LB,  32'h0000_0103, 32'd0, 32'h80FF_FFFF, 1,
            4'b1000, 32'd0, 32'hFFFF_FF80, 1'b1);
    // ack already high in IDLE must not complete anything early
    bus.mem_ack = 1'b1;
    tick();
    bus.mem_ack = 1'b0;
    check("stray_ack_req", 32'(bus.mem_req), 32'd0);
    check("stray_ack_wb",  32'(writeback_en_out), 32'd0);
    mem_txn("sh",  MEM_STORE, F3_SH,  32'h0000_0102, 32'h0000_ABCD, 32'd0, 0,
            4'b1100, 32'hABCD_ABCD, 32'd0, 1'b0);
    mem_txn("sb",  MEM_STORE, F3_SB,  32'h0000_0301, 32'h1234_565A, 32'd0, 2,
            4'b0010, 32'h5A5A_5A5A, 32'd0, 1'b0);
    mem_txn("lhu", MEM_LOAD,  F3_LHU, 32'h0000_0402, 32'd0, 32'h8001_1234, 0,
            4'b1100, 32'd0, 32'h0000_8001, 1'b1);
    mem_txn("lh",  MEM_LOAD,  F3_LH,  32'h0000_0400, 32'd0, 32'h1234_9001, 0,
            4'b0011, 32'd0, 32'hFFFF_9001, 1'b1);
    mem_txn("lbu", MEM_LOAD,  F3_LBU, 32'h0000_0501, 32'd0, 32'h0000_F100, 0,
            4'b0010, 32'd0, 32'h0000_00F1, 1'b1);
    mem_txn("sw",  MEM_STORE, F3_SW,  32'h0000_0600, 32'hCAFE_F00D, 32'd0, 1,
            4'b1111, 32'hCAFE_F00D, 32'd0, 1'b0);

    // reset while BUSY, then a late ack must be ignored
    drive(1'b1, MEM_LOAD, F3_LW, 5'd3, 32'h0000_0200, 32'd0, 1'b1);
    tick();
    check("rstb_req", 32'(bus.mem_req), 32'd1);
    rst = 1'b0;
    drive(1'b0, MEM_NONE, 3'd0, 5'd0, 32'd0, 32'd0, 1'b0);
    tick();
    rst = 1'b1;
    check("rstb_req0",   32'(bus.mem_req), 32'd0);
    check("rstb_we0",    32'(bus.mem_we), 32'd0);
    check("rstb_addr0",  bus.mem_addr, 32'd0);
    check("rstb_wdata0", bus.mem_wdata, 32'd0);
    check("rstb_be0",    32'(bus.mem_be), 32'd0);
    check("rstb_rd0",    rd_out, 32'd0);
    check("rstb_rda0",   32'(rd_addr_out), 32'd0);
    check("rstb_wb0",    32'(writeback_en_out), 32'd0);
    check("rstb_stall0", 32'(stall_out), 32'd0);
    bus.mem_ack = 1'b1; bus.mem_rdata = 32'h1111_2222;
    tick();
    bus.mem_ack = 1'b0;
    check("late_ack_wb", 32'(writeback_en_out), 32'd0);
    check("late_ack_rd", rd_out, 32'd0);
    tick();
    check("late_ack_wb2", 32'(writeback_en_out), 32'd0);

`ifdef MEM_STAGE_MISALIGN_TRAP_EN
    drive(1'b1, MEM_LOAD, F3_LW, 5'd4, 32'h0000_0101, 32'd0, 1'b1);
    #1 check("mis_stall", 32'(stall_out), 32'd0);
    tick();
    check("mis_req", 32'(bus.mem_req), 32'd0);
    check("mis_pulse", 32'(misalign_out), 32'd1);
    check("mis_wb", 32'(writeback_en_out), 32'd0);
    drive(1'b0, MEM_NONE, 3'd0, 5'd0, 32'd0, 32'd0, 1'b0);
    tick();
    check("mis_pulse_end", 32'(misalign_out), 32'd0);
    check("mis_req2", 32'(bus.mem_req), 32'd0);
`else
    mem_txn("lw_mis", MEM_LOAD, F3_LW, 32'h0000_0101, 32'd0, 32'hDEAD_BEEF, 0,
            4'b1111, 32'd0, 32'hDEAD_BEEF, 1'b1);
    check("no_mis", 32'(misalign_out), 32'd0);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
